// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// active-low glyph table, all-off patterns and the digit-index width helper.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF   = 7'b1111111;
   localparam logic [7:0] ANODE_OFF = 8'hFF;

   // Bit 6 is segment a, bit 0 is segment g; a cleared bit lights the segment.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic int sel_width(input int num_digits);
      return (num_digits > 1) ? $clog2(num_digits) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_scan_driver_glyph.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_glyph_rom
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a frame-synchronous double buffer,
// per-slot anode blanking and live leading-zero suppression.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [4*NUM_DIGITS-1:0]          digits_in,
   input  logic [NUM_DIGITS-1:0]            dp_in,
   input  logic [NUM_DIGITS-1:0]            blank_in,
   input  logic                             lz_suppress,
   input  logic                             load,
   output logic [0:6]                       segments,
   output logic                             dp_out,
   output logic [NUM_DIGITS-1:0]            anode_active,
   output logic [sel_width(NUM_DIGITS)-1:0] digit_sel,
   output logic                             update_ack,
   output logic                             frame_done
);

   localparam int SW = sel_width(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODES_DARK = ANODE_OFF[NUM_DIGITS-1:0];

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic                    tick, wrap;

   logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                    valid_q, valid_d;

   logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic                    ack_q, ack_d;
   logic                    frame_q, frame_d;

   logic [3:0]              cur_nibble;
   logic [6:0]              cur_glyph;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic                    zero_above;
   logic                    dark;

   // Prescaler, slot index and the pending/active double buffer.
   always_comb begin
      cnt_d         = cnt_q + 1'b1;
      sel_d         = sel_q;
      tick          = (cnt_q == CNT_LAST);
      wrap          = tick && (sel_q == SEL_LAST);
      pend_digits_d = pend_digits_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      valid_d       = valid_q;
      act_digits_d  = act_digits_q;
      act_dp_d      = act_dp_q;
      act_blank_d   = act_blank_q;

      if (tick) begin
         cnt_d = '0;
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end

      // A load landing on the wrap tick bypasses the pending buffer entirely.
      if (wrap) begin
         if (load) begin
            act_digits_d = digits_in;
            act_dp_d     = dp_in;
            act_blank_d  = blank_in;
         end else if (valid_q) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
         end
         valid_d = 1'b0;
      end else if (load) begin
         pend_digits_d = digits_in;
         pend_dp_d     = dp_in;
         pend_blank_d  = blank_in;
         valid_d       = 1'b1;
      end

      ack_d   = wrap && (load || valid_q);
      frame_d = wrap;
   end

   assign cur_nibble = act_digits_q[4*sel_q +: 4];

   hex_glyph_rom u_glyph (
      .nibble (cur_nibble),
      .glyph  (cur_glyph)
   );

   // Output stage; suppression is evaluated from the most significant digit down.
   always_comb begin
      zero_above = 1'b1;
      lz_dark    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (act_digits_q[4*i +: 4] == 4'h0);
         if (i > 0) begin
            lz_dark[i] = lz_suppress && zero_above;
         end
      end

      dark    = act_blank_q[sel_q] || lz_dark[sel_q];
      seg_d   = dark ? SEG_OFF : cur_glyph;
      dp_d    = act_blank_q[sel_q] ? 1'b1 : ~act_dp_q[sel_q];
      anode_d = ANODES_DARK;
      if (cnt_q >= BLANK_END) begin
         anode_d[sel_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         sel_q         <= '0;
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '0;
         valid_q       <= 1'b0;
         act_digits_q  <= '0;
         act_dp_q      <= '0;
         act_blank_q   <= '0;
         seg_q         <= SEG_OFF;
         dp_q          <= 1'b1;
         anode_q       <= ANODES_DARK;
         ack_q         <= 1'b0;
         frame_q       <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         pend_digits_q <= pend_digits_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         valid_q       <= valid_d;
         act_digits_q  <= act_digits_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         anode_q       <= anode_d;
         ack_q         <= ack_d;
         frame_q       <= frame_d;
      end
   end

   assign segments     = seg_q;
   assign dp_out       = dp_q;
   assign anode_active = anode_q;
   assign digit_sel    = sel_q;
   assign update_ack   = ack_q;
   assign frame_done   = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: edge-count arithmetic model of the scan plus directed
// and randomized load/blank/dp/suppression traffic.
module tb_seven_seg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;
   localparam int FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        lz_suppress = 1'b0;
   logic        load = 1'b0;
   logic [0:6]  segments;
   logic        dp_out;
   logic [3:0]  anode_active;
   logic [1:0]  digit_sel;
   logic        update_ack;
   logic        frame_done;

   seven_seg_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digits_in    (digits_in),
      .dp_in        (dp_in),
      .blank_in     (blank_in),
      .lz_suppress  (lz_suppress),
      .load         (load),
      .segments     (segments),
      .dp_out       (dp_out),
      .anode_active (anode_active),
      .digit_sel    (digit_sel),
      .update_ack   (update_ack),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   logic [6:0] gtab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int checks = 0;
   int errors = 0;

   // Model state: n = rising edges since reset release.
   int          n;
   logic [15:0] m_act_d, m_pend_d;
   logic [3:0]  m_act_dp, m_act_bl, m_pend_dp, m_pend_bl;
   bit          m_valid;
   logic [6:0]  e_seg;
   logic        e_dp, e_ack, e_fd;
   logic [3:0]  e_an;
   logic [1:0]  e_sel;

   int          ack_total = 0;
   int          fd_total = 0;
   logic [6:0]  cap_seg [4];
   logic        cap_dp [4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d t=%0t: got %h expected %h", name, n, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      m_act_d = '0; m_pend_d = '0;
      m_act_dp = '0; m_act_bl = '0; m_pend_dp = '0; m_pend_bl = '0;
      m_valid = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_sel = 2'd0;
      e_ack = 1'b0; e_fd = 1'b0;
   endtask

   // Outputs after edge n show slot state of edge n-1; frames end every FRAME edges.
   task automatic model_step();
      int c, s;
      logic wrap, dk;
      logic [3:0] nib;
      n++;
      c = (n - 1) % RD;
      s = ((n - 1) / RD) % ND;
      nib = m_act_d[4*s +: 4];
      dk = m_act_bl[s] || (lz_suppress && s > 0 && ((m_act_d >> (4*s)) == 16'h0));
      e_seg = dk ? 7'h7F : gtab[nib];
      e_dp  = m_act_bl[s] ? 1'b1 : ~m_act_dp[s];
      e_an  = (c < BC) ? 4'hF : ~(4'b0001 << s);
      e_sel = 2'((n / RD) % ND);
      wrap  = (n % FRAME) == 0;
      e_fd  = wrap;
      e_ack = wrap && (load || m_valid);
      if (wrap) begin
         if (load) begin
            m_act_d = digits_in; m_act_dp = dp_in; m_act_bl = blank_in;
         end else if (m_valid) begin
            m_act_d = m_pend_d; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl;
         end
         m_valid = 1'b0;
      end else if (load) begin
         m_pend_d = digits_in; m_pend_dp = dp_in; m_pend_bl = blank_in;
         m_valid = 1'b1;
      end
   endtask

   task automatic compare();
      chk("segments", {25'd0, segments}, {25'd0, e_seg});
      chk("dp_out", {31'd0, dp_out}, {31'd0, e_dp});
      chk("anode_active", {28'd0, anode_active}, {28'd0, e_an});
      chk("digit_sel", {30'd0, digit_sel}, {30'd0, e_sel});
      chk("update_ack", {31'd0, update_ack}, {31'd0, e_ack});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      compare();
      if (update_ack) ack_total++;
      if (frame_done) fd_total++;
      load = 1'b0;
   endtask

   task automatic run_to(input int target);
      for (int k = 0; k < 200 && n < target; k++) cycle();
   endtask

   task automatic capture(input int cycles);
      int d;
      for (int k = 0; k < 4; k++) begin
         cap_seg[k] = 7'bx;
         cap_dp[k]  = 1'bx;
      end
      for (int k = 0; k < cycles; k++) begin
         cycle();
         case (anode_active)
            4'b1110: d = 0;
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            default: d = -1;
         endcase
         if (d >= 0) begin
            cap_seg[d] = segments;
            cap_dp[d]  = dp_out;
         end
      end
   endtask

   initial begin
      int ack_before, fd_before, ack_n;
      bit got;

      model_reset();
      for (int k = 0; k < 3; k++) cycle();
      rst = 1'b0;

      // Idle scan
      fd_before = fd_total;
      capture(40);
      chk("idle_frame_done_count", fd_total - fd_before, 2);
      chk("idle_sel_at_40", {30'd0, digit_sel}, 32'd2);
      chk("idle_anode_at_40", {28'd0, anode_active}, 32'b1101);
      chk("idle_glyph0", {25'd0, segments}, 32'b0000001);

      // Mid-frame load held until the wrap
      digits_in = 16'h12AF; load = 1'b1;
      cycle();
      got = 1'b0; ack_n = -1;
      for (int k = 0; k < 32 && !got; k++) begin
         cycle();
         if (update_ack) begin
            got = 1'b1;
            ack_n = n;
         end
      end
      chk("load_ack_seen", {31'd0, got}, 32'd1);
      chk("load_ack_edge", ack_n, 32'd48);
      capture(16);
      chk("glyph_d0_F", {25'd0, cap_seg[0]}, 32'b0111000);
      chk("glyph_d1_A", {25'd0, cap_seg[1]}, 32'b0001000);
      chk("glyph_d2_2", {25'd0, cap_seg[2]}, 32'b0010010);
      chk("glyph_d3_1", {25'd0, cap_seg[3]}, 32'b1001111);

      // Leading-zero suppression
      lz_suppress = 1'b1;
      digits_in = 16'h0050; load = 1'b1;
      cycle();
      run_to(80);
      capture(16);
      chk("lz_d3_dark", {25'd0, cap_seg[3]}, 32'b1111111);
      chk("lz_d2_dark", {25'd0, cap_seg[2]}, 32'b1111111);
      chk("lz_d1_5", {25'd0, cap_seg[1]}, 32'b0100100);
      chk("lz_d0_0", {25'd0, cap_seg[0]}, 32'b0000001);
      lz_suppress = 1'b0;

      // Two loads in one frame, last one wins with a single ack
      ack_before = ack_total;
      digits_in = 16'h1111; load = 1'b1;
      cycle();
      cycle(); cycle();
      digits_in = 16'h2222; load = 1'b1;
      cycle();
      run_to(112);
      chk("double_load_ack_count", ack_total - ack_before, 1);
      capture(16);
      chk("double_load_d3", {25'd0, cap_seg[3]}, 32'b0010010);
      chk("double_load_d0", {25'd0, cap_seg[0]}, 32'b0010010);

      // Load on the wrap tick activates immediately and leaves nothing pending
      run_to(143);
      digits_in = 16'h3456; load = 1'b1;
      cycle();
      chk("coincident_ack", {31'd0, update_ack}, 32'd1);
      ack_before = ack_total;
      capture(16);
      chk("coincident_no_second_ack", ack_total - ack_before, 0);
      chk("coincident_d0_6", {25'd0, cap_seg[0]}, 32'b0100000);
      chk("coincident_d3_3", {25'd0, cap_seg[3]}, 32'b0000110);

      // Blank and decimal points
      digits_in = 16'h8888; blank_in = 4'b0100; dp_in = 4'b0101; load = 1'b1;
      cycle();
      run_to(176);
      capture(16);
      chk("blank_d2_dark", {25'd0, cap_seg[2]}, 32'b1111111);
      chk("blank_d2_dp_hidden", {31'd0, cap_dp[2]}, 32'd1);
      chk("dp_d0_lit", {31'd0, cap_dp[0]}, 32'd0);
      chk("dp_d1_off", {31'd0, cap_dp[1]}, 32'd1);
      chk("d0_glyph_8", {25'd0, cap_seg[0]}, 32'b0000000);

      // Asynchronous reset mid-slot discards pending data
      digits_in = 16'h9999; blank_in = 4'b0000; dp_in = 4'b1111; load = 1'b1;
      cycle();
      cycle(); cycle(); cycle();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_segments", {25'd0, segments}, 32'b1111111);
      chk("async_rst_dp", {31'd0, dp_out}, 32'd1);
      chk("async_rst_anode", {28'd0, anode_active}, 32'hF);
      chk("async_rst_sel", {30'd0, digit_sel}, 32'd0);
      chk("async_rst_ack", {31'd0, update_ack}, 32'd0);
      chk("async_rst_fd", {31'd0, frame_done}, 32'd0);
      model_reset();
      cycle(); cycle();
      rst = 1'b0;
      ack_before = ack_total;
      capture(17);
      chk("post_rst_no_ack", ack_total - ack_before, 0);
      chk("post_rst_d3_zero", {25'd0, cap_seg[3]}, 32'b0000001);
      chk("post_rst_dp_off", {31'd0, cap_dp[1]}, 32'd1);

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         load      = ($urandom_range(0, 7) == 0);
         digits_in = 16'($urandom);
         dp_in     = 4'($urandom);
         blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
